// File: rtl/hazard_fwd_unit_pkg.sv
// rtl/hazard_fwd_unit_pkg.sv - shared constants and types for the ID-stage hazard/forwarding unit
// Purpose: forwarding-select encodings, stall FSM state encoding, register-zero constant.
package hazard_fwd_unit_pkg;

  localparam logic [1:0] FWD_REG     = 2'd0;
  localparam logic [1:0] FWD_EXE_ALU = 2'd1;
  localparam logic [1:0] FWD_MEM_ALU = 2'd2;
  localparam logic [1:0] FWD_MEM_LW  = 2'd3;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/hazard_fwd_unit_if.sv
// rtl/hazard_fwd_unit_if.sv - ID/EXE control fields in, forwarding selects and stall controls out
// Ports: ID_rs/ID_rt/ID_use_rs/ID_use_rt (ID operand usage), EXE_wreg/EXE_m2reg/
// EXE_write_reg_number/EXE_bubble (EXE control fields), ID_fwda/ID_fwdb (operand selects),
// wpcir (PC and IF/ID write enable), ID_bubble (bubble into ID/EXE).
// master = pipeline side driving the fields, slave = hazard unit.
interface hazard_fwd_unit_if;

  logic [4:0] ID_rs;
  logic [4:0] ID_rt;
  logic       ID_use_rs;
  logic       ID_use_rt;
  logic       EXE_wreg;
  logic       EXE_m2reg;
  logic [4:0] EXE_write_reg_number;
  logic       EXE_bubble;
  logic [1:0] ID_fwda;
  logic [1:0] ID_fwdb;
  logic       wpcir;
  logic       ID_bubble;

  modport master (
    output ID_rs, ID_rt, ID_use_rs, ID_use_rt,
    output EXE_wreg, EXE_m2reg, EXE_write_reg_number, EXE_bubble,
    input  ID_fwda, ID_fwdb, wpcir, ID_bubble
  );

  modport slave (
    input  ID_rs, ID_rt, ID_use_rs, ID_use_rt,
    input  EXE_wreg, EXE_m2reg, EXE_write_reg_number, EXE_bubble,
    output ID_fwda, ID_fwdb, wpcir, ID_bubble
  );

endinterface

// File: rtl/hazard_fwd_unit_fwd_select.sv
// rtl/hazard_fwd_unit_fwd_select.sv - combinational forwarding priority mux for one ID operand
// Ports: i_src/i_use (operand register and whether it is read), i_exe_wr/i_exe_m2reg/i_exe_dest
// (live EXE writer), i_mem_wr/i_mem_m2reg/i_mem_dest (MEM shadow), o_sel (operand select),
// o_exe_hit (EXE writes this operand; reused for load-use detection).
module hazard_fwd_unit_fwd_select
  import hazard_fwd_unit_pkg::*;
(
  input  logic [4:0] i_src,
  input  logic       i_use,
  input  logic       i_exe_wr,
  input  logic       i_exe_m2reg,
  input  logic [4:0] i_exe_dest,
  input  logic       i_mem_wr,
  input  logic       i_mem_m2reg,
  input  logic [4:0] i_mem_dest,
  output logic [1:0] o_sel,
  output logic       o_exe_hit
);

  logic w_src_live;
  logic w_mem_hit;

  // r0 is hardwired zero, so it never participates in forwarding or hazards.
  assign w_src_live = i_use & (i_src != REG_ZERO);
  assign o_exe_hit  = w_src_live & i_exe_wr & (i_exe_dest == i_src);
  assign w_mem_hit  = w_src_live & i_mem_wr & (i_mem_dest == i_src);

  // A matching EXE load cannot supply data yet; it falls through to the MEM
  // check and the stall logic holds ID until the value is reachable.
  always_comb begin
    o_sel = FWD_REG;
    if (o_exe_hit && !i_exe_m2reg) begin
      o_sel = FWD_EXE_ALU;
    end else if (w_mem_hit) begin
      o_sel = i_mem_m2reg ? FWD_MEM_LW : FWD_MEM_ALU;
    end
  end

endmodule

// File: rtl/hazard_fwd_unit.sv
// rtl/hazard_fwd_unit.sv - ID-stage hazard detection, operand forwarding and load-use stall control
// Ports: clock, resetn (async active-low), bus (hazard_fwd_unit_if.slave: ID/EXE fields in,
// forwarding selects, wpcir and ID_bubble out), stall_count (cycles with wpcir=0),
// bubble_count (cycles with EXE_bubble=1).
module hazard_fwd_unit
  import hazard_fwd_unit_pkg::*;
#(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_W             = 32
) (
  input  logic                 clock,
  input  logic                 resetn,
  hazard_fwd_unit_if.slave     bus,
  output logic [CNT_W-1:0]     stall_count,
  output logic [CNT_W-1:0]     bubble_count
);

  localparam bit         MULTI_STALL = (LOAD_STALL_CYCLES > 1);
  localparam logic [1:0] HOLD_INIT   = MULTI_STALL ? 2'(LOAD_STALL_CYCLES - 2) : 2'd0;

  logic       r_mem_wreg;
  logic       r_mem_m2reg;
  logic [4:0] r_mem_dest;
  state_t     r_state;
  logic [1:0] r_cnt;
  logic [CNT_W-1:0] r_stall_count;
  logic [CNT_W-1:0] r_bubble_count;

  logic       w_exe_wr;
  logic       w_hit_a;
  logic       w_hit_b;
  logic [1:0] w_sel_a;
  logic [1:0] w_sel_b;
  logic       w_lu;
  logic       w_stall;
  logic       w_stall_out;
  state_t     w_state_nxt;
  logic [1:0] w_cnt_nxt;

  assign w_exe_wr = bus.EXE_wreg & ~bus.EXE_bubble;

  hazard_fwd_unit_fwd_select u_sel_rs (
    .i_src       (bus.ID_rs),
    .i_use       (bus.ID_use_rs),
    .i_exe_wr    (w_exe_wr),
    .i_exe_m2reg (bus.EXE_m2reg),
    .i_exe_dest  (bus.EXE_write_reg_number),
    .i_mem_wr    (r_mem_wreg),
    .i_mem_m2reg (r_mem_m2reg),
    .i_mem_dest  (r_mem_dest),
    .o_sel       (w_sel_a),
    .o_exe_hit   (w_hit_a)
  );

  hazard_fwd_unit_fwd_select u_sel_rt (
    .i_src       (bus.ID_rt),
    .i_use       (bus.ID_use_rt),
    .i_exe_wr    (w_exe_wr),
    .i_exe_m2reg (bus.EXE_m2reg),
    .i_exe_dest  (bus.EXE_write_reg_number),
    .i_mem_wr    (r_mem_wreg),
    .i_mem_m2reg (r_mem_m2reg),
    .i_mem_dest  (r_mem_dest),
    .o_sel       (w_sel_b),
    .o_exe_hit   (w_hit_b)
  );

  assign w_lu = (w_hit_a | w_hit_b) & bus.EXE_m2reg;

  // MEM shadow: what the EXE slot holds now is what MEM holds next cycle.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_mem_wreg  <= 1'b0;
      r_mem_m2reg <= 1'b0;
      r_mem_dest  <= REG_ZERO;
    end else begin
      r_mem_wreg  <= bus.EXE_wreg & ~bus.EXE_bubble;
      r_mem_m2reg <= bus.EXE_m2reg & ~bus.EXE_bubble;
      r_mem_dest  <= bus.EXE_write_reg_number;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= RUN;
      r_cnt   <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // RUN stalls for the first cycle of a load-use; HOLD covers the remaining
  // LOAD_STALL_CYCLES-1 cycles while the load works through a slow memory.
  always_comb begin
    w_stall     = 1'b0;
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      RUN: begin
        w_stall = w_lu;
        if (w_lu && MULTI_STALL) begin
          w_state_nxt = HOLD;
          w_cnt_nxt   = HOLD_INIT;
        end
      end
      HOLD: begin
        w_stall = 1'b1;
        if (r_cnt == 2'd0) begin
          w_state_nxt = RUN;
        end else begin
          w_cnt_nxt = r_cnt - 2'd1;
        end
      end
      default: begin
        w_state_nxt = RUN;
      end
    endcase
  end

  // Outputs are forced idle while reset is asserted, independent of the
  // combinational paths from the ID/EXE fields.
  assign w_stall_out   = w_stall & resetn;
  assign bus.wpcir     = ~w_stall_out;
  assign bus.ID_bubble = w_stall_out;
  assign bus.ID_fwda   = resetn ? w_sel_a : FWD_REG;
  assign bus.ID_fwdb   = resetn ? w_sel_b : FWD_REG;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_stall_count  <= '0;
      r_bubble_count <= '0;
    end else begin
      if (w_stall_out) begin
        r_stall_count <= r_stall_count + CNT_W'(1);
      end
      if (bus.EXE_bubble) begin
        r_bubble_count <= r_bubble_count + CNT_W'(1);
      end
    end
  end

  assign stall_count  = r_stall_count;
  assign bubble_count = r_bubble_count;

endmodule
